// File: rtl/ac_unit.sv
// ---------------------------------------------------------------------------
// ac_unit
//
// Accumulator unit for the CPU datapath. Holds the accumulator AC, the
// extend/carry bit E and the upper half HI of the most recent product.
//
// Supported operations:
//   - Single-cycle register-transfer operations on AC and E.
//   - A multi-cycle unsigned shift-add multiply (MUL).
//
// The control unit issues an operation by presenting OP and DATA_IN with
// OP_VALID high. The operation is taken at the next rising edge unless a
// multiply is still in progress (BUSY high). An operation offered while
// BUSY is high is dropped, not queued.
//
// Parameters:
//   WIDTH  data width of AC, DATA_IN, DATA_OUT and HI_OUT (>= 2)
//   CNT_W  multiply iteration counter width (2**CNT_W > WIDTH)
//
// Ports:
//   clk       system clock, rising edge active
//   REST      asynchronous active-high reset
//   DATA_IN   operand from the bus
//   OP        operation code
//   OP_VALID  OP and DATA_IN are valid this cycle
//   BUSY      multiply in progress; new operations are ignored
//   DONE      registered one-cycle pulse when a product is written
//   DATA_OUT  AC register contents
//   HI_OUT    upper half of the last product
//   E_OUT     extend/carry bit
//   ZERO      AC == 0 (combinational)
//   NEG       AC sign bit (combinational)
// ---------------------------------------------------------------------------
module ac_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             REST,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic [3:0]       OP,
    input  logic             OP_VALID,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic [WIDTH-1:0] HI_OUT,
    output logic             E_OUT,
    output logic             ZERO,
    output logic             NEG
);

    // Operation codes; 12..15 are reserved and fall through as no-ops.
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_CLR  = 4'd1;
    localparam logic [3:0] OP_LOAD = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_CMA  = 4'd5;
    localparam logic [3:0] OP_INC  = 4'd6;
    localparam logic [3:0] OP_CIR  = 4'd7;
    localparam logic [3:0] OP_CIL  = 4'd8;
    localparam logic [3:0] OP_CLE  = 4'd9;
    localparam logic [3:0] OP_CME  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE,
        MULT
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       ac_q, ac_d;
    logic                   e_q, e_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic                   done_q, done_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       mplr_q, mplr_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;

    logic [WIDTH:0]         addSum;
    logic [WIDTH:0]         stepSum;
    logic [2*WIDTH-1:0]     prodStep;

    // Datapath helpers: the ADD result with its carry-out, and one
    // shift-add multiply step. The step adds the multiplicand into the
    // upper half of the product when the current multiplier bit is set,
    // then shifts the whole product (including the add's carry) right by
    // one. After WIDTH steps the product register holds the full result.
    always_comb begin
        addSum   = {1'b0, ac_q} + {1'b0, DATA_IN};
        stepSum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (mplr_q[0] ? mcand_q : {WIDTH{1'b0}})};
        prodStep = {stepSum, prod_q[WIDTH-1:1]};
    end

    // Next-state logic. Every register holds by default; DONE is a pulse
    // so it defaults low. In IDLE an offered operation is executed; in
    // MULT the offered operation is simply ignored. The final multiply
    // step writes AC/HI/E straight from the step result so the product is
    // visible in the same cycle DONE is high.
    always_comb begin
        state_d = state_q;
        ac_d    = ac_q;
        e_d     = e_q;
        hi_d    = hi_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mplr_d  = mplr_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;

        case (state_q)
            IDLE: begin
                if (OP_VALID) begin
                    case (OP)
                        OP_NOP:  ;
                        OP_CLR:  ac_d = '0;
                        OP_LOAD: ac_d = DATA_IN;
                        OP_ADD: begin
                            ac_d = addSum[WIDTH-1:0];
                            e_d  = addSum[WIDTH];
                        end
                        OP_AND:  ac_d = ac_q & DATA_IN;
                        OP_CMA:  ac_d = ~ac_q;
                        OP_INC:  ac_d = ac_q + WIDTH'(1);
                        OP_CIR: begin
                            ac_d = {e_q, ac_q[WIDTH-1:1]};
                            e_d  = ac_q[0];
                        end
                        OP_CIL: begin
                            ac_d = {ac_q[WIDTH-2:0], e_q};
                            e_d  = ac_q[WIDTH-1];
                        end
                        OP_CLE:  e_d = 1'b0;
                        OP_CME:  e_d = ~e_q;
                        OP_MUL: begin
                            mplr_d  = ac_q;
                            mcand_d = DATA_IN;
                            prod_d  = '0;
                            cnt_d   = CNT_LOAD;
                            state_d = MULT;
                        end
                        default: ;
                    endcase
                end
            end

            MULT: begin
                prod_d = prodStep;
                mplr_d = mplr_q >> 1;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    ac_d    = prodStep[WIDTH-1:0];
                    hi_d    = prodStep[2*WIDTH-1:WIDTH];
                    e_d     = |prodStep[2*WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State register. Reset is asynchronous so a multiply in flight is
    // abandoned immediately and leaves no partial result behind.
    always_ff @(posedge clk or posedge REST) begin
        if (REST) begin
            state_q <= IDLE;
            ac_q    <= '0;
            e_q     <= 1'b0;
            hi_q    <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mplr_q  <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            ac_q    <= ac_d;
            e_q     <= e_d;
            hi_q    <= hi_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mplr_q  <= mplr_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    // Outputs. ZERO and NEG are decoded from AC so they follow reset
    // without needing a clock edge.
    always_comb begin
        BUSY     = (state_q == MULT);
        DONE     = done_q;
        DATA_OUT = ac_q;
        HI_OUT   = hi_q;
        E_OUT    = e_q;
        ZERO     = (ac_q == '0);
        NEG      = ac_q[WIDTH-1];
    end

endmodule

// File: tb/tb_ac_unit.sv
// ---------------------------------------------------------------------------
// tb_ac_unit
//
// Self-checking bench for ac_unit (WIDTH=16). Directed scenarios from the
// feature list are followed by a randomized run. A behavioural model
// (mAc/mE/mHi) is updated from each operation's arithmetic meaning, and
// the multiply result comes from a plain 32-bit product.
// ---------------------------------------------------------------------------
module tb_ac_unit;

    localparam int W = 16;

    localparam logic [3:0] NOP  = 4'd0;
    localparam logic [3:0] CLR  = 4'd1;
    localparam logic [3:0] LOAD = 4'd2;
    localparam logic [3:0] ADD  = 4'd3;
    localparam logic [3:0] ANDOP = 4'd4;
    localparam logic [3:0] CMA  = 4'd5;
    localparam logic [3:0] INC  = 4'd6;
    localparam logic [3:0] CIR  = 4'd7;
    localparam logic [3:0] CIL  = 4'd8;
    localparam logic [3:0] CLE  = 4'd9;
    localparam logic [3:0] CME  = 4'd10;
    localparam logic [3:0] MUL  = 4'd11;

    logic          clk;
    logic          rest;
    logic [W-1:0]  dataIn;
    logic [3:0]    op;
    logic          opValid;
    logic          busy;
    logic          done;
    logic [W-1:0]  dataOut;
    logic [W-1:0]  hiOut;
    logic          eOut;
    logic          zero;
    logic          neg;

    logic [W-1:0]  mAc;
    logic          mE;
    logic [W-1:0]  mHi;

    int checks;
    int failures;

    ac_unit #(.WIDTH(W), .CNT_W(5)) dut (
        .clk      (clk),
        .REST     (rest),
        .DATA_IN  (dataIn),
        .OP       (op),
        .OP_VALID (opValid),
        .BUSY     (busy),
        .DONE     (done),
        .DATA_OUT (dataOut),
        .HI_OUT   (hiOut),
        .E_OUT    (eOut),
        .ZERO     (zero),
        .NEG      (neg)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural effect of one accepted operation on the model state.
    task automatic modelApply(input logic [3:0] o, input logic [W-1:0] d);
        logic [W:0]     s;
        logic [2*W-1:0] prod;
        logic           t;
        case (o)
            CLR:   mAc = '0;
            LOAD:  mAc = d;
            ADD: begin
                s   = {1'b0, mAc} + {1'b0, d};
                mE  = s[W];
                mAc = s[W-1:0];
            end
            ANDOP: mAc = mAc & d;
            CMA:   mAc = ~mAc;
            INC:   mAc = mAc + 16'd1;
            CIR: begin
                t   = mAc[0];
                mAc = {mE, mAc[W-1:1]};
                mE  = t;
            end
            CIL: begin
                t   = mAc[W-1];
                mAc = {mAc[W-2:0], mE};
                mE  = t;
            end
            CLE:   mE = 1'b0;
            CME:   mE = ~mE;
            MUL: begin
                prod = 32'(mAc) * 32'(d);
                mAc  = prod[W-1:0];
                mHi  = prod[2*W-1:W];
                mE   = (mHi != '0);
            end
            default: ;
        endcase
    endtask

    task automatic modelReset();
        mAc = '0;
        mE  = 1'b0;
        mHi = '0;
    endtask

    // Offer one operation for a single edge. Returns at the falling edge
    // after the accepting edge, where the result (or BUSY) is visible.
    task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] d);
        @(negedge clk);
        op      = o;
        dataIn  = d;
        opValid = 1'b1;
        @(negedge clk);
        opValid = 1'b0;
        modelApply(o, d);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (dataOut !== 16'h0000 || eOut !== 1'b0 || hiOut !== 16'h0000 ||
            busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1 || neg !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_initial: ac=%h e=%b hi=%h busy=%b done=%b zero=%b neg=%b required ac=0 e=0 hi=0 busy=0 done=0 zero=1 neg=0",
                     dataOut, eOut, hiOut, busy, done, zero, neg);
        end
        @(negedge clk);
        rest = 1'b0;
        modelReset();

        applyStimulus(LOAD, 16'h1234);
        applyStimulus(CME, 16'h0000);
        checks++;
        if (dataOut !== 16'h1234 || eOut !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_setup: ac=%h e=%b required ac=1234 e=1", dataOut, eOut);
        end

        // Assert reset in the middle of the low phase, away from any edge.
        @(negedge clk);
        #2;
        rest = 1'b1;
        #1;
        checks++;
        if (dataOut !== 16'h0000 || eOut !== 1'b0 || hiOut !== 16'h0000 ||
            busy !== 1'b0 || zero !== 1'b1 || neg !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_async: ac=%h e=%b hi=%h busy=%b zero=%b neg=%b required ac=0 e=0 hi=0 busy=0 zero=1 neg=0",
                     dataOut, eOut, hiOut, busy, zero, neg);
        end
        @(negedge clk);
        rest = 1'b0;
        modelReset();
    endtask

    task automatic test_arith();
        applyStimulus(LOAD, 16'hFFFF);
        applyStimulus(ADD, 16'h0001);
        checks++;
        if (dataOut !== 16'h0000 || eOut !== 1'b1 || zero !== 1'b1) begin
            failures++;
            $display("[TB] FAIL add_carry: ac=%h e=%b zero=%b required ac=0000 e=1 zero=1", dataOut, eOut, zero);
        end
        applyStimulus(INC, 16'h0000);
        checks++;
        if (dataOut !== 16'h0001 || eOut !== 1'b1) begin
            failures++;
            $display("[TB] FAIL inc: ac=%h e=%b required ac=0001 e=1", dataOut, eOut);
        end
        applyStimulus(CMA, 16'h0000);
        checks++;
        if (dataOut !== 16'hFFFE || neg !== 1'b1 || zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cma: ac=%h neg=%b zero=%b required ac=fffe neg=1 zero=0", dataOut, neg, zero);
        end
        applyStimulus(LOAD, 16'hF0F0);
        applyStimulus(ANDOP, 16'h3C3C);
        checks++;
        if (dataOut !== 16'h3030) begin
            failures++;
            $display("[TB] FAIL and: ac=%h required ac=3030", dataOut);
        end
        applyStimulus(CLR, 16'hAAAA);
        checks++;
        if (dataOut !== 16'h0000 || eOut !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clr: ac=%h e=%b required ac=0000 e=1", dataOut, eOut);
        end
    endtask

    task automatic test_rotate();
        applyStimulus(LOAD, 16'h8001);
        applyStimulus(CLE, 16'h0000);
        applyStimulus(CIL, 16'h0000);
        checks++;
        if (dataOut !== 16'h0002 || eOut !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cil: ac=%h e=%b required ac=0002 e=1", dataOut, eOut);
        end
        applyStimulus(CIR, 16'h0000);
        checks++;
        if (dataOut !== 16'h8001 || eOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cir: ac=%h e=%b required ac=8001 e=0", dataOut, eOut);
        end
        applyStimulus(CME, 16'h0000);
        checks++;
        if (eOut !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cme: e=%b required e=1", eOut);
        end
        applyStimulus(CLE, 16'h0000);
        checks++;
        if (eOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cle: e=%b required e=0", eOut);
        end
    endtask

    task automatic test_mul();
        int busyCycles;
        applyStimulus(LOAD, 16'h0123);
        applyStimulus(MUL, 16'h0100);
        busyCycles = 0;
        // While busy, AC must hold and a LOAD offered midway must be dropped.
        while (busy === 1'b1 && busyCycles < 40) begin
            checks++;
            if (dataOut !== 16'h0123 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mul_hold: cycle=%0d ac=%h done=%b required ac=0123 done=0", busyCycles, dataOut, done);
            end
            op      = LOAD;
            dataIn  = 16'h5555;
            opValid = (busyCycles == 3);
            busyCycles++;
            @(negedge clk);
        end
        opValid = 1'b0;
        checks++;
        if (busyCycles != 16) begin
            failures++;
            $display("[TB] FAIL mul_busy_len: busy cycles=%0d required 16", busyCycles);
        end
        checks++;
        if (dataOut !== 16'h2300 || hiOut !== 16'h0001 || eOut !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mul_result: ac=%h hi=%h e=%b done=%b required ac=2300 hi=0001 e=1 done=1",
                     dataOut, hiOut, eOut, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || dataOut !== 16'h2300) begin
            failures++;
            $display("[TB] FAIL mul_done_pulse: done=%b ac=%h required done=0 ac=2300", done, dataOut);
        end
    endtask

    task automatic test_back_to_back();
        int waitCycles;
        applyStimulus(LOAD, 16'h00FF);
        applyStimulus(MUL, 16'h0002);
        waitCycles = 0;
        while (busy === 1'b1 && waitCycles < 40) begin
            waitCycles++;
            @(negedge clk);
        end
        checks++;
        if (dataOut !== 16'h01FE || hiOut !== 16'h0000 || eOut !== 1'b0 || done !== 1'b1 || waitCycles != 16) begin
            failures++;
            $display("[TB] FAIL mul_small: ac=%h hi=%h e=%b done=%b cycles=%0d required ac=01fe hi=0000 e=0 done=1 cycles=16",
                     dataOut, hiOut, eOut, done, waitCycles);
        end
        // Offer a LOAD in the DONE cycle; it must be taken at the next edge.
        op      = LOAD;
        dataIn  = 16'h0007;
        opValid = 1'b1;
        @(negedge clk);
        opValid = 1'b0;
        modelApply(LOAD, 16'h0007);
        checks++;
        if (dataOut !== 16'h0007 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_in_done: ac=%h done=%b busy=%b required ac=0007 done=0 busy=0", dataOut, done, busy);
        end
    endtask

    task automatic test_mul_reset();
        int doneSeen;
        applyStimulus(LOAD, 16'h0003);
        applyStimulus(MUL, 16'h0005);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mul_reset_busy: busy=%b required 1", busy);
        end
        #2;
        rest = 1'b1;
        #1;
        checks++;
        if (dataOut !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || hiOut !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL mul_reset_clear: ac=%h busy=%b done=%b hi=%h required ac=0 busy=0 done=0 hi=0",
                     dataOut, busy, done, hiOut);
        end
        doneSeen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
        end
        rest = 1'b0;
        modelReset();
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
        end
        checks++;
        if (doneSeen != 0 || dataOut !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL mul_reset_no_done: done/busy seen=%0d ac=%h required seen=0 ac=0000", doneSeen, dataOut);
        end
        applyStimulus(LOAD, 16'h0009);
        checks++;
        if (dataOut !== 16'h0009) begin
            failures++;
            $display("[TB] FAIL load_after_reset: ac=%h required ac=0009", dataOut);
        end
    endtask

    task automatic test_random();
        logic [3:0] o;
        logic [W-1:0] d;
        int waitCycles;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            d = 16'($urandom);
            applyStimulus(o, d);
            if (o == MUL) begin
                waitCycles = 0;
                while (busy === 1'b1 && waitCycles < 40) begin
                    waitCycles++;
                    @(negedge clk);
                end
                checks++;
                if (waitCycles != 16 || done !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL rand_mul_timing: iter=%0d cycles=%0d done=%b required cycles=16 done=1", i, waitCycles, done);
                end
            end else begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL rand_ctrl: iter=%0d op=%0d busy=%b done=%b required busy=0 done=0", i, o, busy, done);
                end
            end
            checks++;
            if (dataOut !== mAc || eOut !== mE || hiOut !== mHi ||
                zero !== (mAc == '0) || neg !== mAc[W-1]) begin
                failures++;
                $display("[TB] FAIL rand_state: iter=%0d op=%0d din=%h ac=%h e=%b hi=%h zero=%b neg=%b required ac=%h e=%b hi=%h zero=%b neg=%b",
                         i, o, d, dataOut, eOut, hiOut, zero, neg, mAc, mE, mHi, (mAc == '0), mAc[W-1]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rest     = 1'b1;
        opValid  = 1'b0;
        op       = NOP;
        dataIn   = '0;
        modelReset();

        test_reset();
        test_arith();
        test_rotate();
        test_mul();
        test_back_to_back();
        test_mul_reset();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
